mod_step_sched: RTL and testbench
=================================

# mod_step_sched

Round-robin scheduler that time-shares one modular-step datapath among N requesters. The datapath computes (operand + STEP) mod MODULUS, with the sum truncated to W bits before reduction. Each requester presents an operand with a valid/ready handshake. The block grants one requester at a time and reduces the sum by iterative subtraction over one or more cycles. It returns the result on a single tagged response channel and is the front end for the combinational step/mod unit generated for the top level.

## Interface
- N, default 4: number of requesters, N ≥ 2.
- W, default 7: operand/result width.
- STEP, default 1: constant addend, W bits.
- MODULUS, default 100: reduction modulus, 1 ≤ MODULUS ≤ 2^W; 2^W means no effective reduction.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- req_valid  input  N  per-requester operand valid.
- req_ready  output  N  per-requester accept; one-hot or zero.
- req_data  input  N*W  operands; requester i occupies bits [i*W +: W].
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  W  reduced result.
- rsp_id  output  clog2(N)  index of the requester the result belongs to.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, CALC, RESP.
- **IDLE**
  - Grant g = first i with req_valid[i]=1, searching cyclically from last_grant+1.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - If no request is valid, req_ready=0 and the block stays in IDLE.
  - On handshake (req_valid[g] & req_ready[g] at the edge):
    - acc ← (req_data[g] + STEP) truncated to W bits; the carry out is discarded, so 127+1 = 0 for W=7.
    - id ← g; last_grant ← g; next state CALC.
- **CALC**
  - If acc ≥ MODULUS: acc ← acc − MODULUS and stay in CALC.
  - Otherwise go to RESP.
  - req_ready=0 throughout.
- **RESP**
  - rsp_valid=1, rsp_data=acc, rsp_id=id.
  - All three outputs are held stable until rsp_ready=1 at an edge, then the next state is IDLE.
  - rsp_valid & rsp_ready in the same cycle completes the transaction; there is no combinational path from rsp_ready to req_ready.
- Only one transaction is in flight. New requests are not accepted until the block returns to IDLE.
- Round-robin is starvation-free: a continuously valid requester is granted within N transactions.
- Requesters must hold req_valid and req_data until accepted. Deasserting req_valid before acceptance is legal, and that requester is simply skipped.
- Arithmetic is unsigned. acc is W bits; the compare and subtract use W+1 bits so that MODULUS = 2^W is handled.

## Timing
- **Reset** (rst=0 at an edge), regardless of state:
  - state ← IDLE, last_grant ← N−1, so requester 0 wins first.
  - acc, id ← 0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req_ready=0 while rst=0.
  - Any in-flight transaction is discarded and no response is emitted for it.
- **Latency**: with the accept edge at cycle k, rsp_valid first goes high in cycle k+2+s, where s is the number of subtractions.
  - s = floor(acc/MODULUS); for W=7, MODULUS=100, s ≤ 1.
- **Throughput**: with rsp_ready held high, one result every 3+s cycles. IDLE costs one cycle between transactions when a request is already pending.
- rsp_data and rsp_id are registered; no output depends combinationally on rsp_ready.
- req_ready depends combinationally only on req_valid and internal state.

## Test plan
- Reset, then req_valid[0]=1, data=5, rsp_ready=1 -> accept in first IDLE cycle; rsp_valid two cycles later with rsp_data=6, rsp_id=0, asserted for one cycle.
- Requester 2, data=99 -> rsp_data=0 (100 mod 100), rsp_id=2; latency 3 cycles, one subtraction.
- Requester 1, data=127 -> W-bit wrap gives acc=0; rsp_data=0, latency 2 cycles, no subtraction.
- All four req_valid held high with fixed data 10,20,30,40 -> responses in id order 0,1,2,3,0,1 with data 11,21,31,41; no requester granted twice before the others.
- rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0 despite pending requests; completion on the first rsp_ready=1 edge.
- rst driven low during CALC for data=99 -> next cycle busy=0, rsp_valid=0, rsp_data=0; no response emitted for the aborted operand; after release, simultaneous requests on 0 and 3 grant 0 first.

Source files
------------

// File: rtl/mod_step_sched.sv
// Round-robin front end that shares one (operand + STEP) mod MODULUS datapath among N requesters.
// One transaction in flight; the result is held on the tagged response channel until it is accepted.
module mod_step_sched #(
  parameter int N       = 4,
  parameter int W       = 7,
  parameter int STEP    = 1,
  parameter int MODULUS = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*W-1:0]         req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W-1:0]           rsp_data,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic                   busy
);

  localparam int IW = $clog2(N);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [W:0]   MOD_W  = (W+1)'(MODULUS);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [IW-1:0]   id_q, id_d;
  logic [IW-1:0]   last_q, last_d;

  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic [W-1:0]    sel_data;
  logic [W:0]      sub_w;

  // Walk from the farthest candidate to the nearest so the nearest valid one after last_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % N);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) sel_data = req_data[i*W +: W];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    id_d      = id_q;
    last_d    = last_q;
    req_ready = '0;
    // Compare and subtract one bit wider so MODULUS = 2^W never reduces.
    sub_w     = {1'b0, acc_q} - MOD_W;
    case (state_q)
      IDLE: begin
        if (grant_vld && rst) begin
          req_ready[grant_idx] = 1'b1;
          acc_d   = sel_data + STEP_W;
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        if ({1'b0, acc_q} >= MOD_W) acc_d = sub_w[W-1:0];
        else                        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      id_q    <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = acc_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mod_step_sched.sv
// Bench for mod_step_sched: directed vector table, hand-written reset/backpressure sequences,
// and randomized transactions checked against an arithmetic round-robin model.
module tb_mod_step_sched;

  localparam int N   = 4;
  localparam int W   = 7;
  localparam int STP = 1;
  localparam int MOD = 100;
  localparam int IW  = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int last_g;

  mod_step_sched #(.N(N), .W(W), .STEP(STP), .MODULUS(MOD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   mask;
    logic [N*W-1:0] data;
    int             stall;
    int             eid;
    int             edat;
    int             elat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the operand, cyclic search for the grant.
  function automatic int model_val(input int d);
    return ((d + STP) % (1 << W)) % MOD;
  endfunction

  function automatic int model_lat(input int d);
    return 2 + ((d + STP) % (1 << W)) / MOD;
  endfunction

  function automatic int model_grant(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst    = 1'b1;
    last_g = N - 1;
  endtask

  // Drive one request set, check grant, latency, response and hold behaviour.
  task automatic do_txn(input logic [N-1:0] mask, input logic [N*W-1:0] data, input int stall,
                        input int eid, input int edat, input int elat);
    int c;
    logic [N-1:0] one;
    one       = N'(1) << eid;
    req_valid = mask;
    req_data  = data;
    rsp_ready = (stall == 0);
    #1;
    chk("grant", int'(req_ready), int'(one));
    step();
    req_valid = mask & ~one;
    last_g    = eid;
    chk("ready_in_calc", int'(req_ready), 0);
    c = 1;
    while (!rsp_valid && c < 20) begin
      step();
      c++;
    end
    chk("latency", c, elat);
    chk("rsp_data", int'(rsp_data), edat);
    chk("rsp_id", int'(rsp_id), eid);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_data", int'(rsp_data), edat);
      chk("hold_id", int'(rsp_id), eid);
      chk("hold_ready0", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("rsp_one_cycle", int'(rsp_valid), 0);
    chk("idle_after", int'(busy), 0);
  endtask

  vec_t vt[6];

  initial begin
    logic [N-1:0]   m;
    logic [N*W-1:0] d;
    int g, dv, st;

    vt[0] = '{4'b0001, {7'd0, 7'd0, 7'd0, 7'd5},    0, 0, 6,  2};
    vt[1] = '{4'b0100, {7'd0, 7'd99, 7'd0, 7'd0},   0, 2, 0,  3};
    vt[2] = '{4'b0010, {7'd0, 7'd0, 7'd127, 7'd0},  0, 1, 0,  2};
    vt[3] = '{4'b1001, {7'd98, 7'd0, 7'd0, 7'd1},   0, 3, 99, 2};
    vt[4] = '{4'b1111, {7'd40, 7'd30, 7'd20, 7'd1}, 5, 0, 2,  2};
    vt[5] = '{4'b0100, {7'd0, 7'd126, 7'd0, 7'd0},  1, 2, 27, 3};

    // Reset state, with requests pending while reset is held.
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    do_reset();

    for (int i = 0; i < 6; i++)
      do_txn(vt[i].mask, vt[i].data, vt[i].stall, vt[i].eid, vt[i].edat, vt[i].elat);
    req_valid = '0;

    // Continuous requests from all four: strict rotation 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 6; i++)
      do_txn(4'b1111, {7'd40, 7'd30, 7'd20, 7'd10}, 0, i % N, 10 * (i % N + 1) + 1, 2);
    req_valid = '0;

    // Reset during CALC discards the operand; requester 0 wins afterwards.
    do_reset();
    req_valid = 4'b0001;
    req_data  = {7'd0, 7'd0, 7'd0, 7'd99};
    step();
    req_valid = '0;
    chk("abort_in_calc", int'(busy), 1);
    rst = 1'b0;
    step();
    chk("abort_busy", int'(busy), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_rsp_data", int'(rsp_data), 0);
    req_valid = 4'b1001;
    #1;
    chk("abort_ready_in_rst", int'(req_ready), 0);
    step();
    chk("abort_no_rsp", int'(rsp_valid), 0);
    rst    = 1'b1;
    last_g = N - 1;
    do_txn(4'b1001, {7'd7, 7'd0, 7'd0, 7'd3}, 0, 0, 4, 2);
    req_valid = '0;

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      m  = N'($urandom_range(1, (1 << N) - 1));
      d  = '0;
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      st = $urandom_range(0, 3);
      g  = model_grant(m, last_g);
      dv = int'(d[g*W +: W]);
      do_txn(m, d, st, g, model_val(dv), model_lat(dv));
    end
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
